// File: rtl/ls_unit_pkg.sv
// Shared constants for the load/store unit: data widths, opcode encodings,
// memory size codes and FSM state codes.
package ls_unit_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int OPENUM_WIDTH = 3;
  localparam int ROB_ID_WIDTH = 4;

  typedef logic [DATA_WIDTH-1:0]   data_t;
  typedef logic [ADDR_WIDTH-1:0]   addr_t;
  typedef logic [OPENUM_WIDTH-1:0] openum_t;
  typedef logic [ROB_ID_WIDTH-1:0] robId_t;

  // Loads occupy the codes up to OPENUM_LHU; everything above is a store.
  localparam openum_t OPENUM_LB  = 3'd0;
  localparam openum_t OPENUM_LH  = 3'd1;
  localparam openum_t OPENUM_LW  = 3'd2;
  localparam openum_t OPENUM_LBU = 3'd3;
  localparam openum_t OPENUM_LHU = 3'd4;
  localparam openum_t OPENUM_SB  = 3'd5;
  localparam openum_t OPENUM_SH  = 3'd6;
  localparam openum_t OPENUM_SW  = 3'd7;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_REPLY    = 2'd2
  } state_e;

  localparam robId_t ZERO_ROB  = '0;
  localparam data_t  ZERO_WORD = '0;

  function automatic logic isLoad(input openum_t op);
    return op <= OPENUM_LHU;
  endfunction

endpackage

// File: rtl/ls_unit_extend.sv
// Narrows raw memory read data to the load width and sign- or zero-extends
// it back to a full word.
module ls_extend
  import ls_unit_pkg::*;
(
  input  openum_t op_i,
  input  data_t   raw_i,
  output data_t   ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (op_i)
      OPENUM_LB:  ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      OPENUM_LBU: ext_o = {24'd0, raw_i[7:0]};
      OPENUM_LH:  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      OPENUM_LHU: ext_o = {16'd0, raw_i[15:0]};
      default:    ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// Load/store unit: runs one memory operation at a time against the memory
// controller and broadcasts extended load results on the LS-unit CDB.
module ls_unit
  import ls_unit_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    enable_signal_from_lsb,
  input  openum_t openum_from_lsb,
  input  addr_t   mem_address_from_lsb,
  input  data_t   stored_data_from_lsb,
  input  robId_t  rob_id_from_lsb,
  output logic    busy_signal_to_lsb,
  output logic    mem_req_valid,
  output logic    mem_req_write,
  output logic [1:0] mem_req_size,
  output addr_t   mem_req_addr,
  output data_t   mem_req_data,
  input  logic    mem_done,
  input  data_t   mem_rdata,
  output logic    valid_signal_to_cdb,
  output robId_t  rob_id_to_cdb,
  output data_t   result_to_cdb,
  input  logic    misbranch_flag
);

  state_e     state_q, state_d;
  logic       kill_q, kill_d;
  openum_t    op_q;
  addr_t      addr_q;
  data_t      data_q;
  robId_t     robId_q;
  logic       write_q;
  logic [1:0] size_q;
  data_t      result_q;

  logic       reqIsLoad;
  logic       accept;
  logic       loadDone;
  logic [1:0] reqSize;
  data_t      extData;

  // A load issued in the same cycle as a flush is on the wrong path; stores are post-commit.
  assign reqIsLoad = isLoad(openum_from_lsb);
  assign accept    = (state_q == ST_IDLE) && enable_signal_from_lsb
                     && !(reqIsLoad && misbranch_flag);
  assign loadDone  = (state_q == ST_WAIT_MEM) && mem_done && !write_q;

  always_comb begin
    reqSize = MEM_WORD;
    case (openum_from_lsb)
      OPENUM_LB, OPENUM_LBU, OPENUM_SB: reqSize = MEM_BYTE;
      OPENUM_LH, OPENUM_LHU, OPENUM_SH: reqSize = MEM_HALF;
      default:                          reqSize = MEM_WORD;
    endcase
  end

  ls_extend u_extend (
    .op_i  (op_q),
    .raw_i (mem_rdata),
    .ext_o (extData)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (accept) state_d = ST_WAIT_MEM;
      end
      ST_WAIT_MEM: begin
        if (!write_q && misbranch_flag) kill_d = 1'b1;
        if (mem_done) begin
          kill_d = 1'b0;
          if (write_q || kill_q || misbranch_flag) state_d = ST_IDLE;
          else                                     state_d = ST_REPLY;
        end
      end
      ST_REPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= OPENUM_LB;
      addr_q   <= '0;
      data_q   <= ZERO_WORD;
      robId_q  <= ZERO_ROB;
      write_q  <= 1'b0;
      size_q   <= MEM_BYTE;
      result_q <= ZERO_WORD;
    end else if (rdy) begin
      if (accept) begin
        op_q    <= openum_from_lsb;
        addr_q  <= mem_address_from_lsb;
        data_q  <= stored_data_from_lsb;
        robId_q <= rob_id_from_lsb;
        write_q <= !reqIsLoad;
        size_q  <= reqSize;
      end
      if (loadDone) result_q <= extData;
    end
  end

  always_comb begin
    busy_signal_to_lsb  = (state_q != ST_IDLE) || enable_signal_from_lsb;
    mem_req_valid       = (state_q == ST_WAIT_MEM);
    valid_signal_to_cdb = (state_q == ST_REPLY) && !misbranch_flag;
    mem_req_write       = write_q;
    mem_req_size        = size_q;
    mem_req_addr        = addr_q;
    mem_req_data        = data_q;
    rob_id_to_cdb       = robId_q;
    result_to_cdb       = result_q;
  end

endmodule

// File: tb/tb_ls_unit.sv
// Directed testbench for ls_unit: load extension, stores, flushes, rdy stalls
// and mid-operation reset, with hand-computed expected values.
module tb_ls_unit;
  import ls_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       enable;
  openum_t    openum;
  addr_t      addrIn;
  data_t      storeData;
  robId_t     robIn;
  logic       busy;
  logic       memReqValid;
  logic       memReqWrite;
  logic [1:0] memReqSize;
  addr_t      memReqAddr;
  data_t      memReqData;
  logic       memDone;
  data_t      memRdata;
  logic       cdbValid;
  robId_t     cdbRob;
  data_t      cdbResult;
  logic       misbranch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ls_unit dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .enable_signal_from_lsb (enable),
    .openum_from_lsb        (openum),
    .mem_address_from_lsb   (addrIn),
    .stored_data_from_lsb   (storeData),
    .rob_id_from_lsb        (robIn),
    .busy_signal_to_lsb     (busy),
    .mem_req_valid          (memReqValid),
    .mem_req_write          (memReqWrite),
    .mem_req_size           (memReqSize),
    .mem_req_addr           (memReqAddr),
    .mem_req_data           (memReqData),
    .mem_done               (memDone),
    .mem_rdata              (memRdata),
    .valid_signal_to_cdb    (cdbValid),
    .rob_id_to_cdb          (cdbRob),
    .result_to_cdb          (cdbResult),
    .misbranch_flag         (misbranch)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input openum_t op, input addr_t a, input data_t d,
                               input robId_t r);
    enable    = 1'b1;
    openum    = op;
    addrIn    = a;
    storeData = d;
    robIn     = r;
    #1;
    checkOutput("busyOnEnable", busy, 1'b1);
    step();
    enable = 1'b0;
    #1;
  endtask

  task automatic runLoad(input string tag, input openum_t op, input addr_t a,
                         input robId_t r, input data_t raw, input logic [1:0] sz,
                         input data_t expected);
    applyStimulus(op, a, 32'h0, r);
    checkOutput({tag, "_reqValid"}, memReqValid, 1'b1);
    checkOutput({tag, "_reqWrite"}, memReqWrite, 1'b0);
    checkOutput({tag, "_reqSize"}, memReqSize, sz);
    checkOutput({tag, "_reqAddr"}, memReqAddr, a);
    checkOutput({tag, "_cdbEarly"}, cdbValid, 1'b0);
    memDone  = 1'b1;
    memRdata = raw;
    step();
    memDone  = 1'b0;
    memRdata = 32'hA5A5A5A5;
    #1;
    checkOutput({tag, "_cdbValid"}, cdbValid, 1'b1);
    checkOutput({tag, "_cdbRob"}, cdbRob, r);
    checkOutput({tag, "_cdbResult"}, cdbResult, expected);
    checkOutput({tag, "_reqCleared"}, memReqValid, 1'b0);
    step();
    #1;
    checkOutput({tag, "_cdbOnePulse"}, cdbValid, 1'b0);
    checkOutput({tag, "_busyFree"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; enable = 1'b0; openum = OPENUM_LB; addrIn = '0;
    storeData = '0; robIn = '0; memDone = 1'b0; memRdata = '0; misbranch = 1'b0;
    step();
    step();
    #1;
    checkOutput("rstReqValid", memReqValid, 1'b0);
    checkOutput("rstReqWrite", memReqWrite, 1'b0);
    checkOutput("rstReqSize", memReqSize, 2'd0);
    checkOutput("rstReqAddr", memReqAddr, 32'h0);
    checkOutput("rstCdbValid", cdbValid, 1'b0);
    checkOutput("rstCdbRob", cdbRob, 4'd0);
    checkOutput("rstCdbResult", cdbResult, 32'h0);
    checkOutput("rstBusy", busy, 1'b0);
    rst = 1'b1;
    step();
    #1;

    runLoad("lb",   OPENUM_LB,  32'h100, 4'd3, 32'h000000F0, MEM_BYTE, 32'hFFFFFFF0);
    runLoad("lbu",  OPENUM_LBU, 32'h100, 4'd4, 32'h000000F0, MEM_BYTE, 32'h000000F0);
    runLoad("lbuJ", OPENUM_LBU, 32'h101, 4'd8, 32'h123456F0, MEM_BYTE, 32'h000000F0);
    runLoad("lh",   OPENUM_LH,  32'h102, 4'd10, 32'h00008001, MEM_HALF, 32'hFFFF8001);
    runLoad("lhu",  OPENUM_LHU, 32'h102, 4'd11, 32'h00008001, MEM_HALF, 32'h00008001);
    runLoad("lw",   OPENUM_LW,  32'h104, 4'd12, 32'h12345678, MEM_WORD, 32'h12345678);

    // Store word: fields hold through WAIT_MEM, no CDB broadcast.
    applyStimulus(OPENUM_SW, 32'h200, 32'hDEADBEEF, 4'd7);
    checkOutput("swReqValid", memReqValid, 1'b1);
    checkOutput("swReqWrite", memReqWrite, 1'b1);
    checkOutput("swReqSize", memReqSize, MEM_WORD);
    checkOutput("swReqAddr", memReqAddr, 32'h200);
    checkOutput("swReqData", memReqData, 32'hDEADBEEF);
    step();
    #1;
    checkOutput("swHoldAddr", memReqAddr, 32'h200);
    checkOutput("swHoldData", memReqData, 32'hDEADBEEF);
    checkOutput("swHoldValid", memReqValid, 1'b1);
    memDone = 1'b1;
    #1;
    checkOutput("swBusyAtDone", busy, 1'b1);
    checkOutput("swNoCdb", cdbValid, 1'b0);
    step();
    memDone = 1'b0;
    #1;
    checkOutput("swBusyFree", busy, 1'b0);
    checkOutput("swReqCleared", memReqValid, 1'b0);
    checkOutput("swNoCdbAfter", cdbValid, 1'b0);

    // Load issued together with a flush is dropped.
    enable = 1'b1; openum = OPENUM_LW; addrIn = 32'h120; robIn = 4'd13; misbranch = 1'b1;
    step();
    enable = 1'b0; misbranch = 1'b0;
    #1;
    checkOutput("dropReqValid", memReqValid, 1'b0);
    checkOutput("dropBusy", busy, 1'b0);

    // Load flushed in WAIT_MEM completes its access silently.
    applyStimulus(OPENUM_LW, 32'h140, 32'h0, 4'd5);
    misbranch = 1'b1;
    step();
    misbranch = 1'b0;
    #1;
    checkOutput("killStillReq", memReqValid, 1'b1);
    step();
    step();
    memDone = 1'b1; memRdata = 32'hCAFEF00D;
    step();
    memDone = 1'b0;
    #1;
    checkOutput("killNoCdb", cdbValid, 1'b0);
    checkOutput("killBusy", busy, 1'b0);
    checkOutput("killReqValid", memReqValid, 1'b0);

    // Flush arriving in REPLY suppresses the broadcast.
    applyStimulus(OPENUM_LW, 32'h144, 32'h0, 4'd6);
    memDone = 1'b1; memRdata = 32'h00000042;
    step();
    memDone = 1'b0; misbranch = 1'b1;
    #1;
    checkOutput("replyFlushCdb", cdbValid, 1'b0);
    step();
    misbranch = 1'b0;
    #1;
    checkOutput("replyFlushBusy", busy, 1'b0);

    // Store ignores a flush.
    applyStimulus(OPENUM_SB, 32'h300, 32'h000000AB, 4'd2);
    checkOutput("sbReqSize", memReqSize, MEM_BYTE);
    misbranch = 1'b1;
    step();
    misbranch = 1'b0;
    #1;
    checkOutput("sbFlushReqValid", memReqValid, 1'b1);
    checkOutput("sbFlushBusy", busy, 1'b1);
    step();
    step();
    memDone = 1'b1;
    step();
    memDone = 1'b0;
    #1;
    checkOutput("sbDoneBusy", busy, 1'b0);
    checkOutput("sbDoneReq", memReqValid, 1'b0);
    checkOutput("sbNoCdb", cdbValid, 1'b0);

    // rdy low freezes WAIT_MEM and a done in a stalled cycle is ignored.
    applyStimulus(OPENUM_LH, 32'h180, 32'h0, 4'd9);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memDone  = (i == 1);
      memRdata = 32'h00007FFF;
      #1;
      checkOutput("stallReqValid", memReqValid, 1'b1);
      checkOutput("stallBusy", busy, 1'b1);
      step();
    end
    rdy = 1'b1; memDone = 1'b0;
    #1;
    checkOutput("stallStillWait", memReqValid, 1'b1);
    checkOutput("stallNoCdb", cdbValid, 1'b0);
    memDone = 1'b1; memRdata = 32'h0000FFFF;
    step();
    memDone = 1'b0;
    #1;
    checkOutput("stallCdbValid", cdbValid, 1'b1);
    checkOutput("stallCdbRob", cdbRob, 4'd9);
    checkOutput("stallCdbResult", cdbResult, 32'hFFFFFFFF);
    step();
    #1;
    checkOutput("stallBusyFree", busy, 1'b0);

    // Reset in the middle of WAIT_MEM, then a fresh request.
    applyStimulus(OPENUM_SW, 32'h240, 32'h11223344, 4'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checkOutput("midRstReqValid", memReqValid, 1'b0);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstWrite", memReqWrite, 1'b0);
    checkOutput("midRstAddr", memReqAddr, 32'h0);
    checkOutput("midRstData", memReqData, 32'h0);
    runLoad("postRst", OPENUM_LW, 32'h104, 4'd6, 32'h0BADF00D, MEM_WORD, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
